i2c_regacc: RTL and testbench

//  Register-access front end that sits directly upstream of the i2c byte engine.
//  It takes one host command: write or read an 8-bit register on a 7-bit device.
//  It expands the command into the engine's per-byte req/ack sequence:
//   - write: dev+W, reg, data, STOP
//   - read:  dev+W, reg, repeated START, dev+R, data, STOP
//  It returns a single response with the read data and an error flag.

---
 rtl/i2c_regacc.sv | 215 +++++++++++++++++++++
 tb/tb_i2c_regacc.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_regacc.sv
// ---------------------------------------------------------------------------
// i2c_regacc
//   Register-access front end for the i2c byte engine. Accepts one host
//   command (read or write of an 8-bit register on a 7-bit device), expands
//   it into the engine's per-byte req/ack sequence and returns one response.
//     write: dev+W, reg, data, STOP
//     read : dev+W, reg, repeated START, dev+R, data, STOP
//
// Build option:
//   I2C_REGACC_ADDR16_EN  - when defined, cmd_reg is 16 bits and the register
//                           high byte (REGH) is sent before the low byte.
//
// Parameters:
//   RSTWAIT   cycles cmd_ready stays low after reset, so the engine (which
//             has no reset) can finish any transaction already in flight.
//
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_rd/cmd_dev/cmd_reg/cmd_wdata   host command
//   rsp_valid/rsp_data/rsp_err                             host response
//   addr/wrdata/req/last   byte request to the engine (all registered)
//   rddata/ack/err         per-byte completion from the engine
//
// Handshakes:
//   Host command: transfer happens on a rising edge where cmd_valid and
//   cmd_ready are both high; cmd_ready is high only in IDLE. Response:
//   rsp_valid is a one-cycle strobe with no back-pressure. Engine: req is a
//   one-cycle strobe; addr/wrdata/last stay stable until the matching ack;
//   rddata and err are only looked at in the cycle ack is high.
// ---------------------------------------------------------------------------
module i2c_regacc #(
  parameter int RSTWAIT = 50000,
`ifdef I2C_REGACC_ADDR16_EN
  localparam int RW = 16
`else
  localparam int RW = 8
`endif
) (
  input  logic          clk,
  input  logic          rstn,
  // host command
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_rd,
  input  logic [6:0]    cmd_dev,
  input  logic [RW-1:0] cmd_reg,
  input  logic [7:0]    cmd_wdata,
  // host response
  output logic          rsp_valid,
  output logic [7:0]    rsp_data,
  output logic          rsp_err,
  // to engine
  output logic [7:0]    addr,
  output logic [7:0]    wrdata,
  output logic          req,
  output logic          last,
  // from engine
  input  logic [7:0]    rddata,
  input  logic          ack,
  input  logic          err
);

  typedef enum logic [2:0] {
    RSTW  = 3'd0,
    IDLE  = 3'd1,
`ifdef I2C_REGACC_ADDR16_EN
    REGH  = 3'd2,
`endif
    REGL  = 3'd3,
    WDATA = 3'd4,
    RSEL  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t        state;
  logic [15:0]   cnt;

  // command fields captured at acceptance
  logic          c_rd;
  logic [6:0]    c_dev;
  logic [RW-1:0] c_reg;
  logic [7:0]    c_wdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= RSTW;
      cnt       <= RSTWAIT[15:0];
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_err   <= 1'b0;
      addr      <= 8'h00;
      wrdata    <= 8'h00;
      req       <= 1'b0;
      last      <= 1'b0;
      c_rd      <= 1'b0;
      c_dev     <= 7'h00;
      c_reg     <= '0;
      c_wdata   <= 8'h00;
    end else begin
      // strobes default low; the states below raise them for one cycle
      req       <= 1'b0;
      rsp_valid <= 1'b0;

      case (state)
        // Counter reaches 0, then one more cycle to leave. Acks here belong
        // to a transaction started before reset and are dropped.
        RSTW: begin
          if (cnt == 16'd0) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end

        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            c_rd      <= cmd_rd;
            c_dev     <= cmd_dev;
            c_reg     <= cmd_reg;
            c_wdata   <= cmd_wdata;
            cmd_ready <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b0;
            // first register byte is always sent with the write direction
            req       <= 1'b1;
            addr      <= {cmd_dev, 1'b0};
            last      <= 1'b0;
`ifdef I2C_REGACC_ADDR16_EN
            state     <= REGH;
            wrdata    <= cmd_reg[15:8];
`else
            state     <= REGL;
            wrdata    <= cmd_reg[7:0];
`endif
          end
        end

`ifdef I2C_REGACC_ADDR16_EN
        REGH: begin
          if (ack) begin
            if (err) begin
              // engine already issued STOP; report and stop requesting
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= 8'h00;
            end else begin
              state  <= REGL;
              req    <= 1'b1;
              wrdata <= c_reg[7:0];
            end
          end
        end
`endif

        REGL: begin
          if (ack) begin
            if (err) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= 8'h00;
            end else if (c_rd) begin
              // read direction in addr makes the engine issue repeated START
              state  <= RSEL;
              req    <= 1'b1;
              addr   <= {c_dev, 1'b1};
              wrdata <= 8'h00;
              last   <= 1'b1;
            end else begin
              state  <= WDATA;
              req    <= 1'b1;
              wrdata <= c_wdata;
              last   <= 1'b1;
            end
          end
        end

        WDATA: begin
          if (ack) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_data  <= 8'h00;
          end
        end

        // RSEL both selects read mode and returns the data byte
        RSEL: begin
          if (ack) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_data  <= err ? 8'h00 : rddata;
          end
        end

        // rsp_valid is high during DONE; ready returns the cycle after
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end

        default: begin
          state     <= RSTW;
          cnt       <= RSTWAIT[15:0];
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_regacc.sv
// ---------------------------------------------------------------------------
// tb_i2c_regacc
//   Directed bench for i2c_regacc with RSTWAIT=20. A table of command records
//   (fields, engine ack delay, injected NACK position, expected per-byte
//   engine requests and expected response) is applied in a loop; reset-wait
//   and mid-command reset are hand-written sequences. The engine is modelled
//   inline: it checks each request, waits a few cycles, then acks.
// ---------------------------------------------------------------------------
module tb_i2c_regacc;

`ifdef I2C_REGACC_ADDR16_EN
  localparam int RW = 16;
`else
  localparam int RW = 8;
`endif

  logic          clk;
  logic          rstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rd;
  logic [6:0]    cmd_dev;
  logic [RW-1:0] cmd_reg;
  logic [7:0]    cmd_wdata;
  logic          rsp_valid;
  logic [7:0]    rsp_data;
  logic          rsp_err;
  logic [7:0]    addr;
  logic [7:0]    wrdata;
  logic          req;
  logic          last;
  logic [7:0]    rddata;
  logic          ack;
  logic          err;

  int n_vec = 0;
  int n_err = 0;

  i2c_regacc #(.RSTWAIT(20)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .addr(addr), .wrdata(wrdata), .req(req), .last(last),
    .rddata(rddata), .ack(ack), .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one record per command; byte i of e_addr/e_wd sits at [31-8i -: 8],
  // bit i of e_last at [3-i]; nb = number of requests actually issued
  typedef struct {
    logic          rd;
    logic [6:0]    dev;
    logic [RW-1:0] rg;
    logic [7:0]    wd;
    logic [7:0]    rdd;
    int            err_at;   // 0 = no NACK, n = NACK on ack #n
    int            dly;      // cycles from req to ack
    int            nb;
    logic [31:0]   e_addr;
    logic [31:0]   e_wd;
    logic [3:0]    e_last;
    logic [7:0]    e_data;
    logic          e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rd, logic [6:0] dev, logic [RW-1:0] rg,
                              logic [7:0] wd, logic [7:0] rdd, int err_at,
                              int dly, int nb, logic [31:0] ea,
                              logic [31:0] ew, logic [3:0] el,
                              logic [7:0] ed, logic ee);
    vec_t v;
    v.rd = rd; v.dev = dev; v.rg = rg; v.wd = wd; v.rdd = rdd;
    v.err_at = err_at; v.dly = dly; v.nb = nb;
    v.e_addr = ea; v.e_wd = ew; v.e_last = el; v.e_data = ed; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero();
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_wrdata", 32'(wrdata), 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_last", 32'(last), 0);
  endtask

  // Reset-wait window after rstn release: ready low for 20 edges, high on
  // the 21st. Optional stray ack (and a stray cmd_valid) inside the window.
  task automatic rstw_window(input int ack_at, input logic ack_err);
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
      chk("rstw_ready", 32'(cmd_ready), (k <= 20) ? 0 : 1);
      chk("rstw_req", 32'(req), 0);
      chk("rstw_rsp", 32'(rsp_valid), 0);
      ack       = (k == ack_at);
      err       = (k == ack_at) ? ack_err : 1'b0;
      rddata    = (k == ack_at) ? 8'hEE : 8'h00;
      cmd_valid = (k >= 3 && k <= 8);
    end
    ack = 1'b0; err = 1'b0; rddata = 8'h00; cmd_valid = 1'b0;
  endtask

  // driver + inline engine model for one table record
  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    chk("idle_ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_rd = v.rd; cmd_dev = v.dev;
    cmd_reg = v.rg; cmd_wdata = v.wd;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < v.nb; i++) begin
      chk("req", 32'(req), 1);
      chk("no_early_rsp", 32'(rsp_valid), 0);
      chk("addr", 32'(addr), 32'(v.e_addr[31-8*i -: 8]));
      chk("wrdata", 32'(wrdata), 32'(v.e_wd[31-8*i -: 8]));
      chk("last", 32'(last), 32'(v.e_last[3-i]));
      for (int d = 0; d < v.dly; d++) begin
        @(posedge clk); #1;
        chk("req_one_cycle", 32'(req), 0);
        chk("addr_hold", 32'(addr), 32'(v.e_addr[31-8*i -: 8]));
        chk("wrdata_hold", 32'(wrdata), 32'(v.e_wd[31-8*i -: 8]));
        chk("busy_ready", 32'(cmd_ready), 0);
      end
      ack = 1'b1; err = (v.err_at == i + 1); rddata = v.rdd;
      @(posedge clk); #1;
      ack = 1'b0; err = 1'b0; rddata = 8'h00;
    end
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_data", 32'(rsp_data), 32'(v.e_data));
    chk("rsp_err", 32'(rsp_err), 32'(v.e_err));
    chk("no_req_after", 32'(req), 0);
    chk("done_ready", 32'(cmd_ready), 0);
    @(posedge clk); #1;
    chk("rsp_one_cycle", 32'(rsp_valid), 0);
    chk("ready_after_rsp", 32'(cmd_ready), 1);
    chk("no_req_idle", 32'(req), 0);
  endtask

  initial begin
    rstn = 1'b0; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_dev = 7'h00;
    cmd_reg = '0; cmd_wdata = 8'h00; rddata = 8'h00; ack = 1'b0; err = 1'b0;

`ifdef I2C_REGACC_ADDR16_EN
    //              rd    dev     reg       wd     rdd   erra dly nb  addr          wrdata        last     data   err
    tbl.push_back(mk(1'b0, 7'h50, 16'hBEEF, 8'h01, 8'h33, 0, 2, 3, 32'hA0A0A000, 32'hBEEF0100, 4'b0010, 8'h00, 1'b0));
    tbl.push_back(mk(1'b1, 7'h50, 16'h1234, 8'h00, 8'h5C, 0, 1, 3, 32'hA0A0A100, 32'h12340000, 4'b0010, 8'h5C, 1'b0));
    tbl.push_back(mk(1'b1, 7'h50, 16'h1234, 8'h00, 8'h5C, 1, 1, 1, 32'hA0000000, 32'h12000000, 4'b0000, 8'h00, 1'b1));
    tbl.push_back(mk(1'b0, 7'h2A, 16'h00FF, 8'h99, 8'h44, 2, 3, 2, 32'h54540000, 32'h00FF0000, 4'b0000, 8'h00, 1'b1));
    tbl.push_back(mk(1'b1, 7'h01, 16'h8001, 8'h00, 8'h77, 3, 1, 3, 32'h02020300, 32'h80010000, 4'b0010, 8'h00, 1'b1));
`else
    tbl.push_back(mk(1'b0, 7'h50, 8'h12, 8'hA5, 8'h33, 0, 2, 2, 32'hA0A00000, 32'h12A50000, 4'b0100, 8'h00, 1'b0));
    tbl.push_back(mk(1'b1, 7'h50, 8'h34, 8'h00, 8'h5C, 0, 2, 2, 32'hA0A10000, 32'h34000000, 4'b0100, 8'h5C, 1'b0));
    tbl.push_back(mk(1'b1, 7'h50, 8'h34, 8'h00, 8'h5C, 1, 1, 1, 32'hA0000000, 32'h34000000, 4'b0000, 8'h00, 1'b1));
    tbl.push_back(mk(1'b0, 7'h2A, 8'hFF, 8'h00, 8'h44, 2, 3, 2, 32'h54540000, 32'hFF000000, 4'b0100, 8'h00, 1'b1));
    tbl.push_back(mk(1'b1, 7'h7F, 8'h00, 8'h00, 8'hFF, 0, 1, 2, 32'hFEFF0000, 32'h00000000, 4'b0100, 8'hFF, 1'b0));
    tbl.push_back(mk(1'b1, 7'h01, 8'h80, 8'h00, 8'h77, 2, 1, 2, 32'h02030000, 32'h80000000, 4'b0100, 8'h00, 1'b1));
    tbl.push_back(mk(1'b0, 7'h00, 8'h01, 8'hFF, 8'h00, 0, 5, 2, 32'h00000000, 32'h01FF0000, 4'b0100, 8'h00, 1'b0));
`endif

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero();

    // release reset; stray NACK-ack and stray cmd_valid inside the wait
    rstn = 1'b1;
    rstw_window(5, 1'b1);

    foreach (tbl[i]) run_vec(tbl[i]);

    // reset between req #1 and its ack
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_rd = tbl[0].rd; cmd_dev = tbl[0].dev;
    cmd_reg = tbl[0].rg; cmd_wdata = tbl[0].wd;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("midrst_req1", 32'(req), 1);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk_all_zero();
    @(posedge clk); #1;
    rstn = 1'b1;
    // late ack of the aborted byte arrives in the wait window
    rstw_window(2, 1'b0);

    // next command completes normally
    run_vec(tbl[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
